// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - load/store sequencer for the core data-memory port
//
// Accepts one decoded load/store, drives a word-wide req/ack memory with byte
// enables, and returns the extended load result. The pipeline stalls while busy.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request valid (sampled in IDLE only)
//   mem_read/mem_write load / store strobes
//   mem_ctrl[2:0]      LB LH LW LBU LHU SB SH SW (000..111)
//   addr[31:0]         byte address
//   wdata[31:0]        right-aligned store data
//   busy               state is not IDLE
//   done, fault        one-cycle completion pulse and its failure qualifier
//   rdata[31:0]        extended load result (updated on successful loads only)
//   mreq, mwe          memory request / write enable
//   maddr[31:0]        word-aligned address
//   mwdata[31:0]       lane-replicated store data
//   mbe[3:0]           byte enables, bit i = byte i
//   mack, mrdata[31:0] memory acknowledge and read word (same cycle)

module mem_access_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mbe,
    input  logic        mack,
    input  logic [31:0] mrdata
);

    localparam logic [2:0] C_LB  = 3'b000;
    localparam logic [2:0] C_LH  = 3'b001;
    localparam logic [2:0] C_LW  = 3'b010;
    localparam logic [2:0] C_LBU = 3'b011;
    localparam logic [2:0] C_LHU = 3'b100;
    localparam logic [2:0] C_SB  = 3'b101;
    localparam logic [2:0] C_SH  = 3'b110;
    localparam logic [2:0] C_SW  = 3'b111;

    // Last wait-counter value before the access times out.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_load;
    logic        r_fault;
    logic [2:0]  r_ctrl;
    logic [1:0]  r_alo;
    logic [15:0] r_wait;
    logic        r_mwe;
    logic [31:0] r_maddr;
    logic [31:0] r_mwdata;
    logic [3:0]  r_mbe;
    logic [31:0] r_rdata;

    logic        w_request;
    logic        w_both;
    logic        w_code_bad;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_req_fault;
    logic        w_timeout;
    logic [3:0]  w_mbe;
    logic [31:0] w_mwdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // ---------------- request classification (IDLE inputs) ----------------
    assign w_request    = start && (mem_read || mem_write);
    assign w_both       = mem_read && mem_write;
    assign w_code_bad   = (mem_read && !mem_write && (mem_ctrl >= C_SB)) ||
                          (mem_write && !mem_read && (mem_ctrl <= C_LHU));
    assign w_is_half    = (mem_ctrl == C_LH) || (mem_ctrl == C_LHU) || (mem_ctrl == C_SH);
    assign w_is_word    = (mem_ctrl == C_LW) || (mem_ctrl == C_SW);
    assign w_misaligned = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));
    assign w_req_fault  = w_both || w_code_bad || w_misaligned;

    assign w_timeout    = (r_wait == WAIT_LAST);

    always_comb begin
        w_mbe    = 4'b1111;
        w_mwdata = wdata;
        case (mem_ctrl)
            C_LB, C_LBU, C_SB: begin
                w_mbe    = 4'b0001 << addr[1:0];
                w_mwdata = {4{wdata[7:0]}};
            end
            C_LH, C_LHU, C_SH: begin
                w_mbe    = addr[1] ? 4'b1100 : 4'b0011;
                w_mwdata = {2{wdata[15:0]}};
            end
            default: begin
                w_mbe    = 4'b1111;
                w_mwdata = wdata;
            end
        endcase
    end

    // ---------------- load extraction (uses latched code/offset) ----------------
    assign w_byte = mrdata[{r_alo, 3'b000} +: 8];
    assign w_half = mrdata[{r_alo[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = mrdata;
        case (r_ctrl)
            C_LB:    w_load_ext = {{24{w_byte[7]}}, w_byte};
            C_LH:    w_load_ext = {{16{w_half[15]}}, w_half};
            C_LBU:   w_load_ext = {24'd0, w_byte};
            C_LHU:   w_load_ext = {16'd0, w_half};
            default: w_load_ext = mrdata;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    w_next = w_req_fault ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mack || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from registered state) ----------------
    always_comb begin
        busy   = (r_state != S_IDLE);
        mreq   = (r_state == S_ACCESS);
        mwe    = (r_state == S_ACCESS) && r_mwe;
        done   = (r_state == S_RESP);
        fault  = (r_state == S_RESP) && r_fault;
        maddr  = r_maddr;
        mwdata = r_mwdata;
        mbe    = r_mbe;
        rdata  = r_rdata;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
            r_fault   <= 1'b0;
            r_ctrl    <= 3'd0;
            r_alo     <= 2'd0;
            r_wait    <= 16'd0;
            r_mwe     <= 1'b0;
            r_maddr   <= 32'd0;
            r_mwdata  <= 32'd0;
            r_mbe     <= 4'd0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        r_fault <= w_req_fault;
                        // Memory-side registers only move for accesses that will
                        // reach ACCESS, so they stay constant across that state.
                        if (!w_req_fault) begin
                            r_is_load <= mem_read;
                            r_ctrl    <= mem_ctrl;
                            r_alo     <= addr[1:0];
                            r_mwe     <= mem_write;
                            r_maddr   <= {addr[31:2], 2'b00};
                            r_mbe     <= w_mbe;
                            r_mwdata  <= w_mwdata;
                            r_wait    <= 16'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    // mack takes priority over the timeout in the same cycle.
                    if (mack) begin
                        r_fault <= 1'b0;
                        if (r_is_load) begin
                            r_rdata <= w_load_ext;
                        end
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer

module tb_mem_access_sequencer;

    localparam int TO = 4;

    localparam logic [2:0] C_LB  = 3'b000;
    localparam logic [2:0] C_LH  = 3'b001;
    localparam logic [2:0] C_LW  = 3'b010;
    localparam logic [2:0] C_LBU = 3'b011;
    localparam logic [2:0] C_LHU = 3'b100;
    localparam logic [2:0] C_SB  = 3'b101;
    localparam logic [2:0] C_SH  = 3'b110;
    localparam logic [2:0] C_SW  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_ctrl = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mack = 1'b0;
    logic [31:0] mrdata = 32'd0;
    logic        busy, done, fault, mreq, mwe;
    logic [31:0] rdata, maddr, mwdata;
    logic [3:0]  mbe;

    mem_access_sequencer #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_ctrl (mem_ctrl),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .rdata    (rdata),
        .mreq     (mreq),
        .mwe      (mwe),
        .maddr    (maddr),
        .mwdata   (mwdata),
        .mbe      (mbe),
        .mack     (mack),
        .mrdata   (mrdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_rdata = 32'd0;
    logic        prev_done = 1'b0;

    // Completion monitor: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) check_val("idle_after_resp", {31'd0, busy}, 32'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("fault", {31'd0, fault}, {31'd0, mon_e.fault});
                    check_val("rdata", rdata, mon_e.rdata);
                end
            end
        end
        prev_done = done;
    end

    task automatic run_req(input string name, input logic rd, input logic wr,
                           input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdw,
                           input int ack_at, input logic exp_fault,
                           input logic [31:0] exp_rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input int exp_mreq,
                           input int exp_lat, input logic noise);
        exp_t e;
        int   mreq_n;
        int   lat;
        @(negedge clk);
        check_val({name, "_idle"}, {31'd0, busy}, 32'd0);
        start     = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        mem_ctrl  = ctrl;
        addr      = a;
        wdata     = wd;
        if (!exp_fault && rd) model_rdata = exp_rd;
        e.fault = exp_fault;
        e.rdata = model_rdata;
        sb_q.push_back(e);
        mreq_n = 0;
        lat    = 0;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(negedge clk);
            start = noise;
            mack  = 1'b0;
            if (done) begin
                lat = c;
            end else if (mreq) begin
                mreq_n++;
                check_val({name, "_maddr"}, maddr, a & 32'hFFFF_FFFC);
                check_val({name, "_mbe"}, {28'd0, mbe}, {28'd0, exp_be});
                check_val({name, "_mwe"}, {31'd0, mwe}, {31'd0, wr});
                if (wr) check_val({name, "_mwdata"}, mwdata, exp_wd);
                if (mreq_n == ack_at) begin
                    mack   = 1'b1;
                    mrdata = rdw;
                end
            end
        end
        check_val({name, "_latency"}, lat, exp_lat);
        check_val({name, "_mreq_cycles"}, mreq_n, exp_mreq);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_busy",   {31'd0, busy},  32'd0);
        check_val("rst_done",   {31'd0, done},  32'd0);
        check_val("rst_fault",  {31'd0, fault}, 32'd0);
        check_val("rst_mreq",   {31'd0, mreq},  32'd0);
        check_val("rst_mwe",    {31'd0, mwe},   32'd0);
        check_val("rst_mbe",    {28'd0, mbe},   32'd0);
        check_val("rst_maddr",  maddr,  32'd0);
        check_val("rst_mwdata", mwdata, 32'd0);
        check_val("rst_rdata",  rdata,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //       name       rd  wr  ctrl   addr          wdata         mrdata        ack f  exp_rdata     mbe      mwdata        mreq lat noise
        run_req("lb",      1, 0, C_LB,  32'h0000_1003, 32'h0,        32'h80FF_FF12, 1, 0, 32'hFFFF_FF80, 4'b1000, 32'h0,        1, 2, 0);
        run_req("lbu",     1, 0, C_LBU, 32'h0000_1003, 32'h0,        32'h80FF_FF12, 1, 0, 32'h0000_0080, 4'b1000, 32'h0,        1, 2, 0);
        run_req("sh",      0, 1, C_SH,  32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        4, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 4, 5, 0);
        run_req("lw_mis",  1, 0, C_LW,  32'h0000_0006, 32'h0,        32'h0,         0, 1, 32'h0,        4'b1111, 32'h0,        0, 1, 0);
        run_req("lh_mis",  1, 0, C_LH,  32'h0000_0001, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0011, 32'h0,        0, 1, 0);
        run_req("sw_code", 0, 1, C_LW,  32'h0000_0010, 32'h1234_5678, 32'h0,        0, 1, 32'h0,        4'b1111, 32'h0,        0, 1, 0);
        run_req("both",    1, 1, C_LW,  32'h0000_0010, 32'h0,        32'h0,         0, 1, 32'h0,        4'b1111, 32'h0,        0, 1, 0);
        run_req("ld_code", 1, 0, C_SB,  32'h0000_0010, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0001, 32'h0,        0, 1, 0);
        run_req("lw_to",   1, 0, C_LW,  32'h0000_0030, 32'h0,        32'h0,         0, 1, 32'h0,        4'b1111, 32'h0,       TO, TO+1, 0);
        run_req("lw_ack4", 1, 0, C_LW,  32'h0000_0030, 32'h0,        32'h1234_5678, 4, 0, 32'h1234_5678, 4'b1111, 32'h0,      TO, TO+1, 0);
        run_req("lh_hi",   1, 0, C_LH,  32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 0, 32'hFFFF_8001, 4'b1100, 32'h0,        1, 2, 0);
        run_req("lhu_lo",  1, 0, C_LHU, 32'h0000_0000, 32'h0,        32'h1234_F00D, 2, 0, 32'h0000_F00D, 4'b0011, 32'h0,        2, 3, 0);
        run_req("sb",      0, 1, C_SB,  32'h0000_0005, 32'h1234_56A5, 32'h0,        2, 0, 32'h0,        4'b0010, 32'hA5A5_A5A5, 2, 3, 0);
        run_req("sw",      0, 1, C_SW,  32'h0000_0008, 32'hCAFE_F00D, 32'h0,        1, 0, 32'h0,        4'b1111, 32'hCAFE_F00D, 1, 2, 0);
        run_req("lb_pos",  1, 0, C_LB,  32'h0000_0010, 32'h0,        32'hFFFF_FF7F, 1, 0, 32'h0000_007F, 4'b0001, 32'h0,        1, 2, 0);
        run_req("noise",   1, 0, C_LW,  32'h0000_0020, 32'h0,        32'h0BAD_F00D, 2, 0, 32'h0BAD_F00D, 4'b1111, 32'h0,        2, 3, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("noise_quiet", {31'd0, busy}, 32'd0);

        // Request with neither strobe is dropped.
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_ctrl = C_LW; addr = 32'h0;
        @(negedge clk);
        start = 1'b0;
        check_val("ignored_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of an access.
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_ctrl = C_LW; addr = 32'h0000_0040;
        @(negedge clk);
        start = 1'b0;
        check_val("rst_pre_mreq", {31'd0, mreq}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_mreq",  {31'd0, mreq}, 32'd0);
        check_val("rst_mid_busy",  {31'd0, busy}, 32'd0);
        check_val("rst_mid_done",  {31'd0, done}, 32'd0);
        check_val("rst_mid_rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req("lw_post", 1, 0, C_LW, 32'h0000_0044, 32'h0, 32'h5A5A_1234, 1, 0, 32'h5A5A_1234, 4'b1111, 32'h0, 1, 2, 0);

        @(negedge clk);
        @(negedge clk);
        check_val("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
